// File: rtl/div_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// with a combinational stall request to CTRL and a one-cycle result strobe.
module div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stallreq_for_div,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic             accept;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes; negation only for signed requests
    always_comb begin
        dividend_neg = div_signed & dividend[WIDTH-1];
        divisor_neg  = div_signed & divisor[WIDTH-1];
        abs_dividend = dividend_neg ? (~dividend + WIDTH'(1)) : dividend;
        abs_divisor  = divisor_neg  ? (~divisor  + WIDTH'(1)) : divisor;
        accept       = (state == IDLE) & div_start & ~cancel;
    end

    // One restoring step: shift {rem, quo}, trial-subtract with a carry bit
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? (~quo_nx + WIDTH'(1)) : quo_nx;
        r_fix = neg_r ? (~rem_nx + WIDTH'(1)) : rem_nx;
    end

    // Sequencer state, datapath registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg_q <= dividend_neg ^ divisor_neg;
                        neg_r <= dividend_neg;
                        rem   <= '0;
                        cnt   <= '0;
                        quo   <= abs_dividend;
                        dvsr  <= abs_divisor;
                        if (divisor == '0) begin
                            // Divide by zero skips CALC and reports the raw dividend
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so EX advances in the cycle it captures the result
    assign stallreq_for_div = accept | ((state == CALC) & ~cancel);
    assign busy             = (state != IDLE);
    assign result_valid     = (state == DONE) & ~cancel;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {quotient, remainder}
// plus per-cycle checks of stall/valid/busy timing.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        stallreq_for_div;
    logic        busy;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          tests;
    int          fails;
    logic [63:0] sb[$];

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .div_start        (div_start),
        .div_signed       (div_signed),
        .dividend         (dividend),
        .divisor          (divisor),
        .cancel           (cancel),
        .stallreq_for_div (stallreq_for_div),
        .busy             (busy),
        .result_valid     (result_valid),
        .quotient         (quotient),
        .remainder        (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference divide built on the language operators
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // One full divide; lat is the result cycle, pulse>0 injects an ignored start
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input int pulse);
        logic [63:0] got;
        sb.push_back(exp);
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        #1;
        chk({tag, "_stall_c0"}, 32'(stallreq_for_div), 32'd1);
        step();
        div_start  = 1'b0;
        div_signed = ~sgn;
        dividend   = $urandom;
        divisor    = 32'd0;
        for (int c = 1; c <= lat + 2; c++) begin
            div_start = (c == pulse);
            #1;
            chk($sformatf("%s_stall_c%0d", tag, c), 32'(stallreq_for_div), 32'(c < lat));
            chk($sformatf("%s_valid_c%0d", tag, c), 32'(result_valid), 32'(c == lat));
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= lat));
            if (result_valid) begin
                chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk({tag, "_quotient"}, quotient, got[63:32]);
                    chk({tag, "_remainder"}, remainder, got[31:0]);
                end
            end
            step();
        end
        div_start = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        cancel     = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stallreq_for_div), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        rst = 1'b0;
        step();

        do_div("divu_7_2", 1'b0, 32'd7, 32'd2, {32'd3, 32'd1}, 33, 0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 33, 0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1}, 33, 0);
        do_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678}, 1, 0);
        do_div("div_by0_neg", 1'b1, 32'hF000_0001, 32'd0, {32'hFFFF_FFFF, 32'hF000_0001}, 1, 0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 0);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0}, 33, 0);
        do_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, ref_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9), 33, 0);

        // Cancel at cycle 10 of DIVU 100/7
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        #1;
        chk("cancel_stall_c0", 32'(stallreq_for_div), 32'd1);
        step();
        div_start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            #1;
            chk($sformatf("cancel_busy_c%0d", c), 32'(busy), 32'd1);
            step();
        end
        cancel = 1'b1;
        #1;
        chk("cancel_stall_c10", 32'(stallreq_for_div), 32'd0);
        chk("cancel_valid_c10", 32'(result_valid), 32'd0);
        step();
        cancel = 1'b0;
        for (int c = 11; c < 40; c++) begin
            #1;
            chk($sformatf("cancel_busy_c%0d", c), 32'(busy), 32'd0);
            chk($sformatf("cancel_stall_c%0d", c), 32'(stallreq_for_div), 32'd0);
            chk($sformatf("cancel_valid_c%0d", c), 32'(result_valid), 32'd0);
            step();
        end
        do_div("rerun_100_7", 1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 33, 15);

        // Reset at cycle 20 of a divide
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd999;
        divisor    = 32'd5;
        step();
        div_start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stall", 32'(stallreq_for_div), 32'd0);
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_remainder", remainder, 32'd0);
        for (int c = 22; c < 40; c++) begin
            chk($sformatf("midrst_valid_c%0d", c), 32'(result_valid), 32'd0);
            step();
        end
        do_div("after_rst", 1'b0, 32'd1000, 32'd10, {32'd100, 32'd0}, 33, 0);

        // A few random operand pairs against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 65535);
            do_div($sformatf("rnd%0d", i), 1'(i % 2), ra, rb, ref_div(1'(i % 2), ra, rb), 33, 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
